// File: rtl/rv64_pkg.sv
// Shared RV64 definitions: datapath widths, base opcodes, immediate format
// encoding and the NOP used to fill empty pipeline registers.
package rv64_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/if_id_decode_stage_if.sv
// IF/ID boundary bundle: fetch-side valid/ready beat, flush, and the decoded
// head entry presented to register-read.
//   master : driven by the surrounding pipeline (fetch beat, flush, id_ready)
//   slave  : the decode stage (if_ready and all id_* outputs)
interface if_id_decode_stage_if;
  import rv64_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_ready;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [2:0]      id_funct3;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [6:0]      id_funct7;
  logic [XLEN-1:0] id_imm;
  imm_type_e       id_imm_type;
  logic            id_illegal;

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_opcode, id_rd, id_funct3,
           id_rs1, id_rs2, id_funct7, id_imm, id_imm_type, id_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_opcode, id_rd, id_funct3,
           id_rs1, id_rs2, id_funct7, id_imm, id_imm_type, id_illegal
  );

endinterface

// File: rtl/rv64_imm_gen.sv
// Combinational RV64 immediate generator.
//   instr    : 32-bit instruction word
//   imm_type : immediate format selected by opcode (NONE when no immediate)
//   imm      : immediate sign-extended from instr[31]; zero for NONE
//   illegal  : encoding is not a supported 32-bit base opcode
module rv64_imm_gen
  import rv64_pkg::*;
(
  input  logic [ILEN-1:0] instr,
  output imm_type_e       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0] opcode;
  logic       known;

  assign opcode = instr[6:0];

  always_comb begin
    imm_type = IMM_NONE;
    known    = 1'b1;
    unique case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: imm_type = IMM_I;
      OPC_STORE:                      imm_type = IMM_S;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_JAL:                        imm_type = IMM_J;
      OPC_OP, OPC_OP32, OPC_MISC_MEM: imm_type = IMM_NONE;
      default:                        known    = 1'b0;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (imm_type)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Compressed encodings (instr[1:0] != 2'b11) are not supported here.
  assign illegal = (instr[1:0] != 2'b11) || !known;

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline boundary for the RV64 core.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : slave side of the IF/ID bundle; accepts {pc, instr} beats from fetch
//           into a 2-entry skid buffer (main = head, skid = overflow) and
//           presents the head with its fields and immediate decoded.
// if_ready comes straight from the skid valid register, so there is no
// combinational path from id_ready back to fetch.
module if_id_decode_stage
  import rv64_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  if_id_decode_stage_if.slave bus
);

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_pc_q,    main_pc_d;
  logic [ILEN-1:0] main_instr_q, main_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;

  logic push;
  logic pop;

  assign push = bus.if_valid & ~skid_valid_q;
  assign pop  = main_valid_q & bus.id_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (bus.flush) begin
      // Flush drops both entries and any beat handshaken this cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        // if_ready is low while skid is full, so no push can coincide here.
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_valid_d = 1'b1;
        main_pc_d    = bus.if_pc;
        main_instr_d = bus.if_instr;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = bus.if_pc;
        main_instr_d = bus.if_instr;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = bus.if_pc;
        skid_instr_d = bus.if_instr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign bus.if_ready = ~skid_valid_q;
  assign bus.id_valid = main_valid_q;

  // Fields follow main regardless of id_valid; consumers qualify with id_valid.
  assign bus.id_pc     = main_pc_q;
  assign bus.id_instr  = main_instr_q;
  assign bus.id_opcode = main_instr_q[6:0];
  assign bus.id_rd     = main_instr_q[11:7];
  assign bus.id_funct3 = main_instr_q[14:12];
  assign bus.id_rs1    = main_instr_q[19:15];
  assign bus.id_rs2    = main_instr_q[24:20];
  assign bus.id_funct7 = main_instr_q[31:25];

  rv64_imm_gen u_imm_gen (
    .instr    (main_instr_q),
    .imm_type (bus.id_imm_type),
    .imm      (bus.id_imm),
    .illegal  (bus.id_illegal)
  );

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed bench for the IF/ID decode stage: reset state, decode of several
// encodings, backpressure ordering, flush and reset mid-transfer.
module tb_if_id_decode_stage;
  import rv64_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  if_id_decode_stage_if bus ();

  if_id_decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  initial begin
    reset        = 1'b0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    check("rst_valid",   64'(bus.id_valid),   64'd0);
    check("rst_instr",   64'(bus.id_instr),   64'h13);
    check("rst_pc",      bus.id_pc,           64'h0);
    check("rst_ready",   64'(bus.if_ready),   64'd1);
    check("rst_illegal", 64'(bus.id_illegal), 64'd0);
    check("rst_imm",     bus.id_imm,          64'h0);

    // addi x1, x0, 5
    bus.id_ready = 1'b1;
    drive(1'b1, 64'h0, 32'h0050_0093);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("addi_valid",   64'(bus.id_valid),    64'd1);
    check("addi_pc",      bus.id_pc,            64'h0);
    check("addi_rd",      64'(bus.id_rd),       64'd1);
    check("addi_rs1",     64'(bus.id_rs1),      64'd0);
    check("addi_imm",     bus.id_imm,           64'd5);
    check("addi_type",    64'(bus.id_imm_type), 64'd1);
    check("addi_illegal", 64'(bus.id_illegal),  64'd0);

    // beq x1, x2, -8 (push and pop in the same cycle)
    drive(1'b1, 64'h4, 32'hFE20_8CE3);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("beq_pc",     bus.id_pc,            64'h4);
    check("beq_rs1",    64'(bus.id_rs1),      64'd1);
    check("beq_rs2",    64'(bus.id_rs2),      64'd2);
    check("beq_opcode", 64'(bus.id_opcode),   64'h63);
    check("beq_imm",    bus.id_imm,           64'hFFFF_FFFF_FFFF_FFF8);
    check("beq_type",   64'(bus.id_imm_type), 64'd3);

    // lui x5, 0x80000
    drive(1'b1, 64'h8, 32'h8000_02B7);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("lui_rd",   64'(bus.id_rd),       64'd5);
    check("lui_imm",  bus.id_imm,           64'hFFFF_FFFF_8000_0000);
    check("lui_type", 64'(bus.id_imm_type), 64'd4);

    // Illegal encodings
    drive(1'b1, 64'hC, 32'h0000_0000);
    step();
    check("ill0_illegal", 64'(bus.id_illegal),  64'd1);
    check("ill0_imm",     bus.id_imm,           64'h0);
    check("ill0_type",    64'(bus.id_imm_type), 64'd0);
    drive(1'b1, 64'h10, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("ill1_illegal", 64'(bus.id_illegal),  64'd1);
    check("ill1_imm",     bus.id_imm,           64'h0);
    check("ill1_type",    64'(bus.id_imm_type), 64'd0);
    check("ill1_pc",      bus.id_pc,            64'h10);
    step();
    check("drain_valid", 64'(bus.id_valid), 64'd0);

    // Backpressure: 0 and 4 accepted, 8 stalled until downstream drains.
    bus.id_ready = 1'b0;
    drive(1'b1, 64'h0, NOP_INSTR);
    step();
    drive(1'b1, 64'h4, NOP_INSTR);
    step();
    check("bp_full_ready", 64'(bus.if_ready), 64'd0);
    check("bp_head0",      bus.id_pc,         64'h0);
    drive(1'b1, 64'h8, NOP_INSTR);
    step();
    check("bp_stall_ready", 64'(bus.if_ready), 64'd0);
    check("bp_stall_head",  bus.id_pc,         64'h0);
    bus.id_ready = 1'b1;
    step();
    check("bp_head4",  bus.id_pc,         64'h4);
    check("bp_ready4", 64'(bus.if_ready), 64'd1);
    step();
    check("bp_head8", bus.id_pc, 64'h8);
    drive(1'b1, 64'hC, NOP_INSTR);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("bp_headC",  bus.id_pc,         64'hC);
    check("bp_validC", 64'(bus.id_valid), 64'd1);
    step();
    check("bp_empty", 64'(bus.id_valid), 64'd0);

    // Flush with both entries full and a beat presented.
    bus.id_ready = 1'b0;
    drive(1'b1, 64'h20, NOP_INSTR);
    step();
    drive(1'b1, 64'h24, NOP_INSTR);
    step();
    check("fl_full", 64'(bus.if_ready), 64'd0);
    drive(1'b1, 64'h28, NOP_INSTR);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    check("fl_valid", 64'(bus.id_valid), 64'd0);
    check("fl_ready", 64'(bus.if_ready), 64'd1);
    drive(1'b1, 64'h100, NOP_INSTR);
    step();
    drive(1'b0, 64'h0, 32'h0);
    check("fl_next_valid", 64'(bus.id_valid), 64'd1);
    check("fl_next_pc",    bus.id_pc,         64'h100);

    // Flush discards a beat handshaken in the same cycle.
    drive(1'b1, 64'h200, NOP_INSTR);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    check("fl_hs_valid", 64'(bus.id_valid), 64'd0);
    step();
    check("fl_hs_stays", 64'(bus.id_valid), 64'd0);

    // Reset mid-transfer, together with flush.
    drive(1'b1, 64'h300, 32'h0050_0093);
    step();
    drive(1'b1, 64'h304, 32'h0050_0093);
    step();
    reset     = 1'b0;
    bus.flush = 1'b1;
    step();
    reset     = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    check("mr_valid", 64'(bus.id_valid), 64'd0);
    check("mr_pc",    bus.id_pc,         64'h0);
    check("mr_instr", 64'(bus.id_instr), 64'h13);
    check("mr_ready", 64'(bus.if_ready), 64'd1);
    check("mr_imm",   bus.id_imm,        64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
